// File: rtl/button_conditioner.sv
// button_conditioner: conditions the four raw Pong push-buttons (up, down, left, right).
// Each channel: 2-flop synchronizer -> counter debouncer -> registered rising-edge
// detector -> optional auto-repeat FSM, with an opposite-pair lockout on btn_move.
// Build option: define BTN_AUTOREPEAT_EN to build the auto-repeat FSMs; without it
// btn_move is the press pulse only (opposite-pair rule still applied).
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_move
);

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Reject configurations where a terminal count of N-1 would be meaningless
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 2");
  end

  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] level;
  logic [DW-1:0]  db_cnt [NCH];
  logic [NCH-1:0] rise_c;
  logic [NCH-1:0] rpt_pulse_c;
  logic [NCH-1:0] move_c;

  // Two-flop synchronizer; only s2 is used downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level; btn_level holds the previous level
  assign rise_c = level & ~btn_level;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]    state         [NCH];
  logic [1:0]    state_nxt_c   [NCH];
  logic [RW-1:0] rpt_cnt       [NCH];
  logic [RW-1:0] rpt_cnt_nxt_c [NCH];

  // Repeat FSM state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]   <= ST_IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]   <= state_nxt_c[i];
        rpt_cnt[i] <= rpt_cnt_nxt_c[i];
      end
    end
  end

  // Repeat FSM next state and pulse; a released level aborts with no pulse
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nxt_c[i]   = state[i];
      rpt_cnt_nxt_c[i] = rpt_cnt[i];
      rpt_pulse_c[i]   = 1'b0;
      if (!level[i]) begin
        state_nxt_c[i]   = ST_IDLE;
        rpt_cnt_nxt_c[i] = '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            if (rise_c[i]) begin
              state_nxt_c[i]   = ST_DELAY;
              rpt_cnt_nxt_c[i] = '0;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt[i] == DELAY_LAST) begin
              rpt_pulse_c[i]   = 1'b1;
              rpt_cnt_nxt_c[i] = '0;
              state_nxt_c[i]   = ST_REPEAT;
            end else begin
              rpt_cnt_nxt_c[i] = rpt_cnt[i] + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt[i] == RATE_LAST) begin
              rpt_pulse_c[i]   = 1'b1;
              rpt_cnt_nxt_c[i] = '0;
            end else begin
              rpt_cnt_nxt_c[i] = rpt_cnt[i] + RW'(1);
            end
          end
          default: begin
            state_nxt_c[i]   = ST_IDLE;
            rpt_cnt_nxt_c[i] = '0;
          end
        endcase
      end
    end
  end
`else
  assign rpt_pulse_c = '0;
`endif

  // Move pulses with opposite-pair lockout, judged on the level being registered
  always_comb begin
    move_c = rise_c | rpt_pulse_c;
    if (level[0] & level[1]) move_c[1:0] = 2'b00;
    if (level[2] & level[3]) move_c[3:2] = 2'b00;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      btn_press <= '0;
      btn_move  <= '0;
    end else begin
      btn_level <= level;
      btn_press <= rise_c;
      btn_move  <= move_c;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Expected per-cycle outputs come from timing formulas (press at raw edge + 6, moves at
// press, press+10, then every 3) and are queued before each scenario runs.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = DEB + 2;
  localparam int N   = 64;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_move;

  int n_pass;
  int n_total;

  logic [3:0]  stim  [N];
  logic [3:0]  m_lvl [N];
  logic [3:0]  m_prs [N];
  logic [3:0]  m_mov [N];
  logic [11:0] exp_q [$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_move (btn_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int t = 0; t < N; t++) begin
      stim[t]  = '0;
      m_lvl[t] = '0;
      m_prs[t] = '0;
      m_mov[t] = '0;
    end
  endfunction

  // Raw held high on channel ch from edge rise until edge fall (fall < 0: held)
  function automatic void model_hold(int ch, int rise, int fall);
    int l;
    int f;
    l = rise + LAT;
    f = (fall < 0) ? N + 1000 : fall + LAT;
    for (int t = 0; t < N; t++) begin
      if (t >= rise && (fall < 0 || t < fall)) stim[t][ch] = 1'b1;
      if (t >= l && t < f) m_lvl[t][ch] = 1'b1;
    end
    if (l < N) begin
      m_prs[l][ch] = 1'b1;
      m_mov[l][ch] = 1'b1;
    end
`ifdef BTN_AUTOREPEAT_EN
    for (int t = l + RD; t < f && t < N; t += RR) m_mov[t][ch] = 1'b1;
`endif
  endfunction

  // Apply opposite-pair lockout and push expected {level, press, move} per cycle
  function automatic void model_push(int n);
    logic [3:0] mv;
    for (int t = 0; t < n; t++) begin
      mv = m_mov[t];
      if (m_lvl[t][0] & m_lvl[t][1]) mv[1:0] = 2'b00;
      if (m_lvl[t][2] & m_lvl[t][3]) mv[3:2] = 2'b00;
      exp_q.push_back({m_lvl[t], m_prs[t], mv});
    end
  endfunction

  task automatic dut_reset();
    rst = 1'b1;
    btn_raw = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    model_clear();
    model_hold(0, 0, -1);
    model_hold(1, 0, -1);
    model_hold(2, 0, -1);
    model_hold(3, 0, -1);
    rst = 1'b1;
    btn_raw = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_total++;
      if ({btn_level, btn_press, btn_move} !== 12'h000)
        $display("FAIL reset_hold c=%0d got lvl=%h prs=%h mov=%h want all 0", c, btn_level, btn_press, btn_move);
      else n_pass++;
    end
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      model_push(20);
      for (int c = 0; c < 20; c++) begin
        btn_raw = stim[c];
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++;
        if ({btn_level, btn_press, btn_move} !== e)
          $display("FAIL reset_release pass=%0d c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                   pass, c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
        else n_pass++;
      end
      // A single reset cycle mid-hold discards everything; the held buttons press afresh
      rst = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if ({btn_level, btn_press, btn_move} !== 12'h000)
        $display("FAIL reset_mid pass=%0d got lvl=%h prs=%h mov=%h want all 0", pass, btn_level, btn_press, btn_move);
      else n_pass++;
      rst = 1'b0;
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] e;
    dut_reset();
    model_clear();
    model_hold(0, 0, -1);
    model_push(32);
    for (int c = 0; c < 32; c++) begin
      btn_raw = stim[c];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({btn_level, btn_press, btn_move} !== e)
        $display("FAIL clean_press c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                 c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [11:0] e;
    dut_reset();
    model_clear();
    model_hold(2, 4, -1);
    stim[0][2] = 1'b1;
    stim[2][2] = 1'b1;
    model_push(28);
    for (int c = 0; c < 28; c++) begin
      btn_raw = stim[c];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({btn_level, btn_press, btn_move} !== e)
        $display("FAIL bounce c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                 c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [11:0] e;
    // Drop 14 cycles past the press, then a drop where a repeat would hit the fall cycle
    for (int k = 0; k < 2; k++) begin
      dut_reset();
      model_clear();
      model_hold(3, 0, (k == 0) ? 20 : 22);
      model_push(40);
      for (int c = 0; c < 40; c++) begin
        btn_raw = stim[c];
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++;
        if ({btn_level, btn_press, btn_move} !== e)
          $display("FAIL release k=%0d c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                   k, c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_opposite_pair();
    logic [11:0] e;
    dut_reset();
    model_clear();
    model_hold(0, 0, -1);
    model_hold(1, 20, 40);
    model_push(N);
    for (int c = 0; c < N; c++) begin
      btn_raw = stim[c];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({btn_level, btn_press, btn_move} !== e)
        $display("FAIL opposite_pair c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                 c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    dut_reset();
    model_clear();
    model_hold(1, 0, 10);
    model_hold(1, 20, -1);
    model_push(44);
    for (int c = 0; c < 44; c++) begin
      btn_raw = stim[c];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({btn_level, btn_press, btn_move} !== e)
        $display("FAIL back_to_back c=%0d got lvl=%h prs=%h mov=%h want lvl=%h prs=%h mov=%h",
                 c, btn_level, btn_press, btn_move, e[11:8], e[7:4], e[3:0]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    btn_raw = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_opposite_pair();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
